// File: rtl/sim_step_sched.sv
// Top-level step sequencer for the LBM datapath: image load, commit, then COLLIDE/STREAM steps.
// Optional macro SIM_STEP_LIMIT_EN adds max_steps/run_done to end a run after a step count.
module sim_step_sched #(
  parameter int DEPTH  = 1024,
  parameter int STEP_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              load_req,
  input  logic              s_valid,
  input  logic [31:0]       s_data,
  output logic              s_ready,
  output logic              wr_en,
  output logic [31:0]       wr_data,
  output logic              img_commit,
  output logic              in_collision_state,
  input  logic              collide_done,
  input  logic              stream_done,
  output logic              busy,
  output logic [STEP_W-1:0] step_cnt,
  output logic              err_seq
`ifdef SIM_STEP_LIMIT_EN
  ,
  input  logic [STEP_W-1:0] max_steps,
  output logic              run_done
`endif
);

  localparam int WORDS  = DEPTH / 32;
  localparam int WCNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(WORDS - 1);

  if (DEPTH <= 0 || (DEPTH % 32) != 0) begin : g_depth_check
    $error("sim_step_sched: DEPTH must be a non-zero multiple of 32");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMMIT,
    S_COLLIDE,
    S_STREAM
  } state_t;

  state_t              state_reg;
  logic [WCNT_W-1:0]   word_cnt_reg;
  logic                load_pend_reg;
  logic [STEP_W-1:0]   step_next;
  logic                pend_any;
  logic                limit_hit;

  assign step_next = step_cnt + STEP_W'(1);
  // A request landing on the same cycle as stream_done still counts at this boundary.
  assign pend_any  = load_pend_reg | load_req;

`ifdef SIM_STEP_LIMIT_EN
  assign limit_hit = (max_steps != '0) && (step_next == max_steps);
`else
  assign limit_hit = 1'b0;
`endif

  // Every output is a register updated alongside the state transition that implies it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg          <= S_IDLE;
      word_cnt_reg       <= '0;
      load_pend_reg      <= 1'b0;
      s_ready            <= 1'b0;
      wr_en              <= 1'b0;
      wr_data            <= '0;
      img_commit         <= 1'b0;
      in_collision_state <= 1'b0;
      busy               <= 1'b0;
      step_cnt           <= '0;
      err_seq            <= 1'b0;
`ifdef SIM_STEP_LIMIT_EN
      run_done           <= 1'b0;
`endif
    end else begin
      wr_en      <= 1'b0;
      img_commit <= 1'b0;
`ifdef SIM_STEP_LIMIT_EN
      run_done   <= 1'b0;
`endif
      if (collide_done && state_reg != S_COLLIDE) err_seq <= 1'b1;
      if (stream_done && state_reg != S_STREAM) err_seq <= 1'b1;
      if (load_req && state_reg != S_IDLE) load_pend_reg <= 1'b1;

      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_reg    <= S_LOAD;
            word_cnt_reg <= '0;
            step_cnt     <= '0;
            s_ready      <= 1'b1;
            busy         <= 1'b1;
          end
        end

        S_LOAD: begin
          if (s_valid) begin
            wr_en        <= 1'b1;
            wr_data      <= s_data;
            word_cnt_reg <= word_cnt_reg + WCNT_W'(1);
            // img_commit is raised here so it lines up with the last wr_en strobe.
            if (word_cnt_reg == LAST_WORD) begin
              state_reg  <= S_COMMIT;
              s_ready    <= 1'b0;
              img_commit <= 1'b1;
            end
          end
        end

        S_COMMIT: begin
          // The freshly committed image satisfies any request raised during the load.
          state_reg          <= S_COLLIDE;
          load_pend_reg      <= 1'b0;
          word_cnt_reg       <= '0;
          in_collision_state <= 1'b1;
        end

        S_COLLIDE: begin
          if (collide_done) begin
            state_reg          <= S_STREAM;
            in_collision_state <= 1'b0;
          end
        end

        S_STREAM: begin
          if (stream_done) begin
            step_cnt <= step_next;
            if (limit_hit) begin
              state_reg <= S_IDLE;
              busy      <= 1'b0;
`ifdef SIM_STEP_LIMIT_EN
              run_done  <= 1'b1;
`endif
            end else if (stop) begin
              state_reg <= S_IDLE;
              busy      <= 1'b0;
            end else if (pend_any) begin
              state_reg <= S_LOAD;
              s_ready   <= 1'b1;
            end else begin
              state_reg          <= S_COLLIDE;
              in_collision_state <= 1'b1;
            end
          end
        end

        default: begin
          state_reg          <= S_IDLE;
          s_ready            <= 1'b0;
          in_collision_state <= 1'b0;
          busy               <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sim_step_sched.sv
// Bench for sim_step_sched: directed scenarios with random data/timing, checked every cycle
// against a phase-level reference model and a write-word scoreboard.
module tb_sim_step_sched;

  localparam int DEPTH  = 128;
  localparam int WORDS  = DEPTH / 32;
  localparam int STEP_W = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              load_req = 1'b0;
  logic              s_valid = 1'b0;
  logic [31:0]       s_data = '0;
  logic              collide_done = 1'b0;
  logic              stream_done = 1'b0;
  logic              s_ready;
  logic              wr_en;
  logic [31:0]       wr_data;
  logic              img_commit;
  logic              in_collision_state;
  logic              busy;
  logic [STEP_W-1:0] step_cnt;
  logic              err_seq;
`ifdef SIM_STEP_LIMIT_EN
  logic [STEP_W-1:0] max_steps = '0;
  logic              run_done;
`endif

  always #5 clk = ~clk;

  sim_step_sched #(.DEPTH(DEPTH), .STEP_W(STEP_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .stop(stop),
    .load_req(load_req),
    .s_valid(s_valid),
    .s_data(s_data),
    .s_ready(s_ready),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .img_commit(img_commit),
    .in_collision_state(in_collision_state),
    .collide_done(collide_done),
    .stream_done(stream_done),
    .busy(busy),
    .step_cnt(step_cnt),
    .err_seq(err_seq)
`ifdef SIM_STEP_LIMIT_EN
    ,
    .max_steps(max_steps),
    .run_done(run_done)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reference model: which phase the run is in, plus the counters the rules talk about.
  typedef enum {PH_IDLE, PH_LOAD, PH_COMMIT, PH_COLLIDE, PH_STREAM} phase_t;
  phase_t      ph;
  int          got_words;
  bit          pend;
  int          steps;
  bit          err;
  bit          exp_wr_en;
  bit          exp_run_done;
  logic [31:0] word_q[$];
  int          wr_seen = 0;
  int          commit_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ph = PH_IDLE;
    got_words = 0;
    pend = 0;
    steps = 0;
    err = 0;
    exp_wr_en = 0;
    exp_run_done = 0;
    word_q.delete();
  endtask

  // Applies the rules to the inputs present at a rising edge.
  task automatic model_clock();
    bit hs;
    if (!rst_n) begin
      model_reset();
    end else begin
      hs = (ph == PH_LOAD) && s_valid;
      exp_wr_en = hs;
      exp_run_done = 0;
      if (hs) word_q.push_back(s_data);
      if (collide_done && ph != PH_COLLIDE) err = 1;
      if (stream_done && ph != PH_STREAM) err = 1;
      if (ph == PH_COMMIT) pend = 0;
      else if (load_req && ph != PH_IDLE) pend = 1;
      case (ph)
        PH_IDLE: if (start) begin ph = PH_LOAD; got_words = 0; steps = 0; end
        PH_LOAD: if (hs) begin
          got_words++;
          if (got_words == WORDS) ph = PH_COMMIT;
        end
        PH_COMMIT: begin ph = PH_COLLIDE; got_words = 0; end
        PH_COLLIDE: if (collide_done) ph = PH_STREAM;
        PH_STREAM: if (stream_done) begin
          steps = (steps + 1) % (1 << STEP_W);
`ifdef SIM_STEP_LIMIT_EN
          if (max_steps != 0 && steps == int'(max_steps)) begin
            ph = PH_IDLE;
            exp_run_done = 1;
          end else
`endif
          if (stop) ph = PH_IDLE;
          else if (pend) ph = PH_LOAD;
          else ph = PH_COLLIDE;
        end
        default: ph = PH_IDLE;
      endcase
    end
  endtask

  task automatic check_all();
    if (wr_en === 1'b1) wr_seen++;
    if (img_commit === 1'b1) commit_seen++;
    chk("s_ready", s_ready, ph == PH_LOAD);
    chk("img_commit", img_commit, ph == PH_COMMIT);
    chk("in_collision_state", in_collision_state, ph == PH_COLLIDE);
    chk("busy", busy, ph != PH_IDLE);
    chk("wr_en", wr_en, exp_wr_en);
    if (exp_wr_en) chk("wr_data", wr_data, word_q.pop_front());
    chk("step_cnt", step_cnt, steps);
    chk("err_seq", err_seq, err);
`ifdef SIM_STEP_LIMIT_EN
    chk("run_done", run_done, exp_run_done);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    @(negedge clk);
    check_all();
    start = 0;
    load_req = 0;
    collide_done = 0;
    stream_done = 0;
    s_valid = 0;
  endtask

  task automatic feed_word(input int gap, input logic [31:0] data);
    repeat (gap) tick();
    s_valid = 1;
    s_data = data;
    tick();
  endtask

  // Feeds a full image then steps through the commit cycle; ends in COLLIDE.
  task automatic load_image(input int max_gap);
    for (int i = 0; i < WORDS; i++) feed_word($urandom_range(0, max_gap), $urandom);
    tick();
  endtask

  task automatic do_step(input bit req);
    repeat ($urandom_range(0, 3)) tick();
    collide_done = 1;
    tick();
    repeat ($urandom_range(0, 3)) tick();
    load_req = req;
    stream_done = 1;
    tick();
  endtask

  int base_wr;
  int base_commit;

  initial begin
    model_reset();
    tick();
    tick();
    rst_n = 1;
    tick();

    // Back-to-back words A..D.
    start = 1;
    tick();
    base_wr = wr_seen;
    base_commit = commit_seen;
    feed_word(0, 32'hA);
    feed_word(0, 32'hB);
    feed_word(0, 32'hC);
    feed_word(0, 32'hD);
    tick();
    chk("burst_wr_count", wr_seen - base_wr, 4);
    chk("burst_commit_count", commit_seen - base_commit, 1);

    // Three steps, the last ending with stop held.
    do_step(0);
    do_step(0);
    stop = 1;
    do_step(0);
    stop = 0;
    tick();
    chk("stop_step_cnt", step_cnt, 3);
    chk("stop_busy", busy, 0);

    // Words with valid gaps on cycles 0,3,4,9.
    start = 1;
    tick();
    base_wr = wr_seen;
    feed_word(0, $urandom);
    feed_word(2, $urandom);
    feed_word(0, $urandom);
    feed_word(4, $urandom);
    chk("gap_s_ready_after_last", s_ready, 0);
    tick();
    chk("gap_wr_count", wr_seen - base_wr, 4);

    // Two load requests in COLLIDE coalesce into one reload at the boundary.
    tick();
    load_req = 1;
    tick();
    tick();
    load_req = 1;
    tick();
    collide_done = 1;
    tick();
    stream_done = 1;
    tick();
    chk("reload_s_ready", s_ready, 1);
    base_commit = commit_seen;
    load_image(2);
    chk("reload_commit_count", commit_seen - base_commit, 1);
    chk("reload_back_in_collide", in_collision_state, 1);

    // Misplaced stream_done in COLLIDE.
    stream_done = 1;
    tick();
    chk("seq_err_set", err_seq, 1);
    chk("seq_err_state_kept", in_collision_state, 1);

    // Random step run with occasional reloads.
    for (int n = 0; n < 20; n++) begin
      do_step(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
      if (ph == PH_LOAD) load_image(3);
    end

    // Asynchronous reset in the middle of a load.
    stop = 1;
    do_step(0);
    stop = 0;
    start = 1;
    tick();
    feed_word(0, $urandom);
    feed_word(1, $urandom);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_img_commit", img_commit, 0);
    chk("rst_in_collision", in_collision_state, 0);
    chk("rst_step_cnt", step_cnt, 0);
    chk("rst_err_seq", err_seq, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    tick();
    start = 1;
    tick();
    base_commit = commit_seen;
    load_image(1);
    chk("post_rst_commit_count", commit_seen - base_commit, 1);

`ifdef SIM_STEP_LIMIT_EN
    stop = 1;
    do_step(0);
    stop = 0;
    max_steps = 2;
    start = 1;
    tick();
    load_image(1);
    do_step(1);
    if (ph == PH_LOAD) load_image(1);
    do_step(1);
    tick();
    chk("limit_step_cnt", step_cnt, 2);
    chk("limit_busy", busy, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
